// File: rtl/wb_stage_pkg.sv
// Shared types and helpers for the write-back stage.
//   write_back_op_t : write-back source select coming from the memory stage
//   load_size_t     : load width / signedness
//   reg_file_op_t   : register-file write enable encoding
//   wb_state_t      : write-back FSM state
//   size_legal()    : load sizes that exist for a given XLEN
//   misaligned()    : natural-alignment check of a load offset
package wb_stage_pkg;

  typedef enum logic [1:0] {
    NO_WRITE_BACK   = 2'd0,
    WRITE_BACK_PC   = 2'd1,
    WRITE_BACK_OUT  = 2'd2,
    WRITE_BACK_LOAD = 2'd3
  } write_back_op_t;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LBU = 3'd3,
    LHU = 3'd4,
    LWU = 3'd5,
    LD  = 3'd6
  } load_size_t;

  typedef enum logic {
    NO_REG_DATA    = 1'b0,
    WRITE_REG_DATA = 1'b1
  } reg_file_op_t;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_t;

  // LWU and LD only exist on a 64-bit datapath; anything else is unknown.
  function automatic logic size_legal(input load_size_t size, input int unsigned xlen);
    logic ok;
    case (size)
      LB, LH, LW, LBU, LHU: ok = 1'b1;
      LWU, LD:              ok = (xlen == 64);
      default:              ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic misaligned(input load_size_t size, input logic [2:0] addr_lo);
    logic bad;
    case (size)
      LH, LHU: bad = addr_lo[0];
      LW, LWU: bad = (addr_lo[1:0] != 2'b00);
      LD:      bad = (addr_lo != 3'b000);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/wb_stage_load_extend.sv
// Combinational load lane select and sign/zero extension.
//   data_i    : raw aligned memory word
//   size_i    : load size / signedness
//   addr_lo_i : byte offset of the load within the word
//   data_o    : extended result, XLEN wide
module load_extend
  import wb_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] data_i,
  input  load_size_t      size_i,
  input  logic [2:0]      addr_lo_i,
  output logic [XLEN-1:0] data_o
);

  logic [2:0]      off;
  logic [XLEN-1:0] lane;

  // A 32-bit word only has four byte lanes, so the top offset bit is dropped.
  assign off  = (XLEN == 64) ? addr_lo_i : {1'b0, addr_lo_i[1:0]};
  assign lane = data_i >> {off, 3'b000};

  always_comb begin
    data_o = '0;
    case (size_i)
      LB:      data_o = XLEN'($signed(lane[7:0]));
      LH:      data_o = XLEN'($signed(lane[15:0]));
      LW:      data_o = XLEN'($signed(lane[31:0]));
      LBU:     data_o = XLEN'(lane[7:0]);
      LHU:     data_o = XLEN'(lane[15:0]);
      LWU:     data_o = XLEN'(lane[31:0]);
      LD:      data_o = lane;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage between the memory stage and the register-file write port.
// Selects PC+4, ALU result or extended load data and issues a registered,
// single-cycle register-file write plus a forwarding mirror of it.
//
// Ports:
//   clk, rst                       : core clock, synchronous active-high reset
//   in_valid / in_ready            : upstream handshake
//   in_wb_ctrl, in_load_size       : write-back source and load size
//   in_addr_lo, in_rd              : load byte offset, destination register
//   in_pc_4, in_alu_out            : non-load result candidates
//   mem_rsp_valid, mem_rsp_data    : data-memory load response
//   reg_op, reg_rd, reg_write_data : register-file write port
//   fwd_valid, fwd_rd, fwd_data    : forwarding copy of the write port
//   busy                           : waiting for a load response
//   err_misaligned                 : sticky, a misaligned load was accepted
//   err_spurious_rsp               : sticky, a response arrived while idle
//
// state    | meaning
// IDLE     | no load outstanding, any transaction accepted
// WAIT_MEM | load latched, waiting for mem_rsp_valid
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  write_back_op_t        in_wb_ctrl,
  input  load_size_t            in_load_size,
  input  logic [2:0]            in_addr_lo,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [XLEN-1:0]       in_pc_4,
  input  logic [XLEN-1:0]       in_alu_out,
  input  logic                  mem_rsp_valid,
  input  logic [XLEN-1:0]       mem_rsp_data,
  output reg_file_op_t          reg_op,
  output logic [REG_ADDR_W-1:0] reg_rd,
  output logic [XLEN-1:0]       reg_write_data,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_rd,
  output logic [XLEN-1:0]       fwd_data,
  output logic                  busy,
  output logic                  err_misaligned,
  output logic                  err_spurious_rsp
);

  wb_state_t             state_q, state_d;
  logic [REG_ADDR_W-1:0] ld_rd_q;
  load_size_t            ld_size_q;
  logic [2:0]            ld_addr_q;

  logic                  accept, is_load, rsp_fire;
  logic                  nl_wr, ld_wr;
  logic [XLEN-1:0]       nl_data, ld_data;

  logic                  skid_v_q, skid_v_d;
  logic [REG_ADDR_W-1:0] skid_rd_q, skid_rd_d;
  logic [XLEN-1:0]       skid_data_q, skid_data_d;

  logic                  out_v_d;
  logic [REG_ADDR_W-1:0] out_rd_d;
  logic [XLEN-1:0]       out_data_d;

  reg_file_op_t          reg_op_q;
  logic [REG_ADDR_W-1:0] reg_rd_q;
  logic [XLEN-1:0]       reg_data_q;
  logic                  err_mis_q, err_spur_q;

  assign accept   = in_valid && in_ready;
  // A load of unknown or unsupported size behaves as NO_WRITE_BACK.
  assign is_load  = (in_wb_ctrl == WRITE_BACK_LOAD) && size_legal(in_load_size, XLEN);
  assign rsp_fire = (state_q == WAIT_MEM) && mem_rsp_valid;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept && is_load) state_d = WAIT_MEM;
      WAIT_MEM: if (mem_rsp_valid)     state_d = (accept && is_load) ? WAIT_MEM : IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state_q)
      IDLE:     in_ready = 1'b1;
      WAIT_MEM: begin
        in_ready = mem_rsp_valid;
        busy     = 1'b1;
      end
      default:  in_ready = 1'b0;
    endcase
  end

  // ---------------- result datapath ----------------
  load_extend #(.XLEN(XLEN)) u_load_extend (
    .data_i    (mem_rsp_data),
    .size_i    (ld_size_q),
    .addr_lo_i (ld_addr_q),
    .data_o    (ld_data)
  );

  assign ld_wr   = rsp_fire && !misaligned(ld_size_q, ld_addr_q) && (ld_rd_q != '0);
  assign nl_wr   = accept && !is_load && (in_rd != '0) &&
                   ((in_wb_ctrl == WRITE_BACK_PC) || (in_wb_ctrl == WRITE_BACK_OUT));
  assign nl_data = (in_wb_ctrl == WRITE_BACK_PC) ? in_pc_4 : in_alu_out;

  // A non-load accepted in the load-response cycle collides with the load
  // write; it is parked for one cycle in the skid slot so writes stay in
  // order, one per cycle. The slot keeps draining while non-loads stream in.
  always_comb begin
    out_v_d     = 1'b0;
    out_rd_d    = reg_rd_q;
    out_data_d  = reg_data_q;
    skid_v_d    = 1'b0;
    skid_rd_d   = skid_rd_q;
    skid_data_d = skid_data_q;
    if (skid_v_q) begin
      out_v_d     = 1'b1;
      out_rd_d    = skid_rd_q;
      out_data_d  = skid_data_q;
      skid_v_d    = nl_wr;
      skid_rd_d   = in_rd;
      skid_data_d = nl_data;
    end else if (ld_wr) begin
      out_v_d     = 1'b1;
      out_rd_d    = ld_rd_q;
      out_data_d  = ld_data;
      skid_v_d    = nl_wr;
      skid_rd_d   = in_rd;
      skid_data_d = nl_data;
    end else if (nl_wr) begin
      out_v_d    = 1'b1;
      out_rd_d   = in_rd;
      out_data_d = nl_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_rd_q     <= '0;
      ld_size_q   <= LB;
      ld_addr_q   <= '0;
      skid_v_q    <= 1'b0;
      skid_rd_q   <= '0;
      skid_data_q <= '0;
      reg_op_q    <= NO_REG_DATA;
      reg_rd_q    <= '0;
      reg_data_q  <= '0;
      err_mis_q   <= 1'b0;
      err_spur_q  <= 1'b0;
    end else begin
      if (accept && is_load) begin
        ld_rd_q   <= in_rd;
        ld_size_q <= in_load_size;
        ld_addr_q <= in_addr_lo;
      end
      skid_v_q    <= skid_v_d;
      skid_rd_q   <= skid_rd_d;
      skid_data_q <= skid_data_d;
      reg_op_q    <= out_v_d ? WRITE_REG_DATA : NO_REG_DATA;
      reg_rd_q    <= out_rd_d;
      reg_data_q  <= out_data_d;
      // Misalignment is flagged at accept; the load still waits for its
      // response and then completes without a write.
      if (accept && is_load && misaligned(in_load_size, in_addr_lo)) err_mis_q <= 1'b1;
      if ((state_q == IDLE) && mem_rsp_valid) err_spur_q <= 1'b1;
    end
  end

  assign reg_op           = reg_op_q;
  assign reg_rd           = reg_rd_q;
  assign reg_write_data   = reg_data_q;
  assign fwd_valid        = (reg_op_q == WRITE_REG_DATA);
  assign fwd_rd           = reg_rd_q;
  assign fwd_data         = reg_data_q;
  assign err_misaligned   = err_mis_q;
  assign err_spurious_rsp = err_spur_q;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
  import wb_stage_pkg::*;

  localparam int XLEN = 32;
  localparam int RW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  write_back_op_t  in_wb_ctrl;
  load_size_t      in_load_size;
  logic [2:0]      in_addr_lo;
  logic [RW-1:0]   in_rd;
  logic [XLEN-1:0] in_pc_4;
  logic [XLEN-1:0] in_alu_out;
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rsp_data;
  reg_file_op_t    reg_op;
  logic [RW-1:0]   reg_rd;
  logic [XLEN-1:0] reg_write_data;
  logic            fwd_valid;
  logic [RW-1:0]   fwd_rd;
  logic [XLEN-1:0] fwd_data;
  logic            busy;
  logic            err_misaligned;
  logic            err_spurious_rsp;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_wb_ctrl       (in_wb_ctrl),
    .in_load_size     (in_load_size),
    .in_addr_lo       (in_addr_lo),
    .in_rd            (in_rd),
    .in_pc_4          (in_pc_4),
    .in_alu_out       (in_alu_out),
    .mem_rsp_valid    (mem_rsp_valid),
    .mem_rsp_data     (mem_rsp_data),
    .reg_op           (reg_op),
    .reg_rd           (reg_rd),
    .reg_write_data   (reg_write_data),
    .fwd_valid        (fwd_valid),
    .fwd_rd           (fwd_rd),
    .fwd_data         (fwd_data),
    .busy             (busy),
    .err_misaligned   (err_misaligned),
    .err_spurious_rsp (err_spurious_rsp)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_write(input string tag, input logic [RW-1:0] rd, input logic [XLEN-1:0] data);
    chk({tag, "_op"},   64'(reg_op), 64'(WRITE_REG_DATA));
    chk({tag, "_rd"},   64'(reg_rd), 64'(rd));
    chk({tag, "_data"}, 64'(reg_write_data), 64'(data));
    chk({tag, "_fwdv"}, 64'(fwd_valid), 64'd1);
    chk({tag, "_fwdd"}, 64'(fwd_data), 64'(data));
  endtask

  task automatic offer(input write_back_op_t ctrl, input load_size_t sz, input logic [2:0] a,
                       input logic [RW-1:0] rd, input logic [XLEN-1:0] pc4, input logic [XLEN-1:0] alu);
    in_valid     = 1'b1;
    in_wb_ctrl   = ctrl;
    in_load_size = sz;
    in_addr_lo   = a;
    in_rd        = rd;
    in_pc_4      = pc4;
    in_alu_out   = alu;
  endtask

  task automatic do_load(input string tag, input load_size_t sz, input logic [2:0] a,
                         input logic [RW-1:0] rd, input logic [XLEN-1:0] exp);
    offer(WRITE_BACK_LOAD, sz, a, rd, '0, '0);
    tick();
    in_valid = 1'b0;
    #1;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    chk({tag, "_rdy0"}, 64'(in_ready), 64'd0);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h8081_F2F3;
    #1;
    chk({tag, "_rdy1"}, 64'(in_ready), 64'd1);
    tick();
    mem_rsp_valid = 1'b0;
    chk_write(tag, rd, exp);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
    tick();
    chk({tag, "_once"}, 64'(reg_op), 64'(NO_REG_DATA));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    in_valid      = 1'b0;
    in_wb_ctrl    = NO_WRITE_BACK;
    in_load_size  = LB;
    in_addr_lo    = '0;
    in_rd         = '0;
    in_pc_4       = '0;
    in_alu_out    = '0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_op",   64'(reg_op), 64'(NO_REG_DATA));
    chk("rst_rd",   64'(reg_rd), 64'd0);
    chk("rst_data", 64'(reg_write_data), 64'd0);
    chk("rst_fwdv", 64'(fwd_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rdy",  64'(in_ready), 64'd1);
    chk("rst_emis", 64'(err_misaligned), 64'd0);
    chk("rst_espr", 64'(err_spurious_rsp), 64'd0);

    // Non-load ALU write: one cycle only
    offer(WRITE_BACK_OUT, LB, 3'd0, 5'd5, 32'h0, 32'h0000_1234);
    tick();
    in_valid = 1'b0;
    chk_write("alu", 5'd5, 32'h0000_1234);
    chk("alu_fwdrd", 64'(fwd_rd), 64'd5);
    tick();
    chk("alu_once", 64'(reg_op), 64'(NO_REG_DATA));

    // Loads with extension from 0x8081_F2F3
    do_load("lb1",  LB,  3'd1, 5'd7,  32'hFFFF_FFF2);
    do_load("lbu3", LBU, 3'd3, 5'd8,  32'h0000_0080);
    do_load("lh2",  LH,  3'd2, 5'd9,  32'hFFFF_8081);
    do_load("lhu0", LHU, 3'd0, 5'd10, 32'h0000_F2F3);

    // Back-to-back non-loads: one write per cycle
    offer(WRITE_BACK_PC, LB, 3'd0, 5'd1, 32'h0000_0100, 32'h0);
    tick();
    offer(WRITE_BACK_OUT, LB, 3'd0, 5'd2, 32'h0, 32'h0000_0055);
    chk_write("b2b1", 5'd1, 32'h0000_0100);
    tick();
    in_valid = 1'b0;
    chk_write("b2b2", 5'd2, 32'h0000_0055);
    tick();
    chk("b2b_end", 64'(reg_op), 64'(NO_REG_DATA));

    // Load with delayed response and an ALU op waiting behind it
    offer(WRITE_BACK_LOAD, LW, 3'd0, 5'd9, 32'h0, 32'h0);
    tick();
    offer(WRITE_BACK_OUT, LB, 3'd0, 5'd10, 32'h0, 32'h0000_ABCD);
    for (int i = 0; i < 3; i++) begin
      chk("stall_rdy",  64'(in_ready), 64'd0);
      chk("stall_busy", 64'(busy), 64'd1);
      chk("stall_op",   64'(reg_op), 64'(NO_REG_DATA));
      tick();
    end
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h1122_3344;
    #1;
    chk("stall_rsp_rdy", 64'(in_ready), 64'd1);
    tick();
    in_valid      = 1'b0;
    mem_rsp_valid = 1'b0;
    chk_write("stall_ld", 5'd9, 32'h1122_3344);
    tick();
    chk_write("stall_alu", 5'd10, 32'h0000_ABCD);
    tick();
    chk("stall_end", 64'(reg_op), 64'(NO_REG_DATA));

    // Misaligned LW: flag set, no write, flag sticky
    offer(WRITE_BACK_LOAD, LW, 3'd2, 5'd3, 32'h0, 32'h0);
    tick();
    in_valid = 1'b0;
    chk("mis_flag", 64'(err_misaligned), 64'd1);
    chk("mis_busy", 64'(busy), 64'd1);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    mem_rsp_valid = 1'b0;
    chk("mis_nowr",  64'(reg_op), 64'(NO_REG_DATA));
    chk("mis_idle",  64'(busy), 64'd0);
    tick();
    chk("mis_stick", 64'(err_misaligned), 64'd1);

    // rd == 0: no write, no forwarding
    offer(WRITE_BACK_PC, LB, 3'd0, 5'd0, 32'h0000_0200, 32'h0);
    tick();
    in_valid = 1'b0;
    chk("rd0_op",   64'(reg_op), 64'(NO_REG_DATA));
    chk("rd0_fwdv", 64'(fwd_valid), 64'd0);

    // Spurious response while idle
    chk("spur_pre", 64'(err_spurious_rsp), 64'd0);
    mem_rsp_valid = 1'b1;
    tick();
    mem_rsp_valid = 1'b0;
    chk("spur_flag", 64'(err_spurious_rsp), 64'd1);
    chk("spur_nowr", 64'(reg_op), 64'(NO_REG_DATA));

    // Reset clears sticky flags
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("clr_emis", 64'(err_misaligned), 64'd0);
    chk("clr_espr", 64'(err_spurious_rsp), 64'd0);

    // Reset during WAIT_MEM drops the load
    offer(WRITE_BACK_OUT, LB, 3'd0, 5'd6, 32'h0, 32'h0000_0777);
    tick();
    chk_write("pre_rst", 5'd6, 32'h0000_0777);
    offer(WRITE_BACK_LOAD, LB, 3'd0, 5'd4, 32'h0, 32'h0);
    tick();
    in_valid = 1'b0;
    chk("wrst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("wrst_idle", 64'(busy), 64'd0);
    chk("wrst_op",   64'(reg_op), 64'(NO_REG_DATA));
    chk("wrst_rd",   64'(reg_rd), 64'd0);
    chk("wrst_data", 64'(reg_write_data), 64'd0);
    chk("wrst_fwdd", 64'(fwd_data), 64'd0);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h8081_F2F3;
    tick();
    mem_rsp_valid = 1'b0;
    chk("wrst_spur", 64'(err_spurious_rsp), 64'd1);
    chk("wrst_nowr", 64'(reg_op), 64'(NO_REG_DATA));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
